// File: rtl/full_adder_if.sv
// Operand/result bundle for full_adder; op_count exists only when FULL_ADDER_STATS_EN is defined.
interface full_adder_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             in_valid;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             out_valid;
`ifdef FULL_ADDER_STATS_EN
    logic [CNT_W-1:0] op_count;
`endif

    // Reject illegal parameterisations at elaboration
    if ((WIDTH < 1) || (WIDTH > 32) || (CNT_W < 1)) begin : g_param_err
        $error("full_adder_if: illegal WIDTH/CNT_W");
    end

    modport master (
        output a, b, cin, in_valid,
`ifdef FULL_ADDER_STATS_EN
        input  op_count,
`endif
        input  sum, carry, out_valid
    );

    modport slave (
        input  a, b, cin, in_valid,
`ifdef FULL_ADDER_STATS_EN
        output op_count,
`endif
        output sum, carry, out_valid
    );
endinterface

// File: rtl/full_adder.sv
// Registered WIDTH-bit adder with carry-in/out and one-cycle latency.
// Define FULL_ADDER_STATS_EN to add a saturating accepted-operation counter (op_count).
module full_adder #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    full_adder_if.slave   bus
);
    logic [WIDTH:0]   res_s;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             carry_q;
    logic             carry_d;
    logic             valid_q;
    logic             valid_d;

    // Reject illegal parameterisations at elaboration
    if ((WIDTH < 1) || (WIDTH > 32) || (CNT_W < 1)) begin : g_param_err
        $error("full_adder: illegal WIDTH/CNT_W");
    end

    // WIDTH+1-bit sum so the top bit is the carry-out
    always_comb begin
        res_s = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
    end

    // Load on valid, otherwise hold result and drop out_valid
    always_comb begin
        sum_d   = sum_q;
        carry_d = carry_q;
        valid_d = 1'b0;
        if (bus.in_valid) begin
            sum_d   = res_s[WIDTH-1:0];
            carry_d = res_s[WIDTH];
            valid_d = 1'b1;
        end else begin
            sum_d   = sum_q;
            carry_d = carry_q;
            valid_d = 1'b0;
        end
    end

    // Result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
        end
    end

    assign bus.sum       = sum_q;
    assign bus.carry     = carry_q;
    assign bus.out_valid = valid_q;

`ifdef FULL_ADDER_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count accepted operations, sticking at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (bus.in_valid && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Operation counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.op_count = cnt_q;
`endif
endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench: WIDTH=1 and WIDTH=8 adders side by side against an arithmetic reference model.
module tb_full_adder;
    logic clk;
    logic rst;

    full_adder_if #(.WIDTH(1), .CNT_W(4)) if1 ();
    full_adder_if #(.WIDTH(8), .CNT_W(4)) if8 ();

    full_adder #(.WIDTH(1), .CNT_W(4)) u1 (.clk(clk), .rst(rst), .bus(if1));
    full_adder #(.WIDTH(8), .CNT_W(4)) u8 (.clk(clk), .rst(rst), .bus(if8));

    int n_cmp;
    int n_bad;

    // reference model state
    int e1_sum, e1_car, e8_sum, e8_car, e_valid, e_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string ctx);
        check_eq({ctx, "/w1_sum"},   64'(if1.sum),       64'(e1_sum));
        check_eq({ctx, "/w1_carry"}, 64'(if1.carry),     64'(e1_car));
        check_eq({ctx, "/w1_valid"}, 64'(if1.out_valid), 64'(e_valid));
        check_eq({ctx, "/w8_sum"},   64'(if8.sum),       64'(e8_sum));
        check_eq({ctx, "/w8_carry"}, 64'(if8.carry),     64'(e8_car));
        check_eq({ctx, "/w8_valid"}, 64'(if8.out_valid), 64'(e_valid));
`ifdef FULL_ADDER_STATS_EN
        check_eq({ctx, "/w1_cnt"},   64'(if1.op_count),  64'(e_cnt));
        check_eq({ctx, "/w8_cnt"},   64'(if8.op_count),  64'(e_cnt));
`endif
    endtask

    task automatic model_reset();
        e1_sum = 0; e1_car = 0; e8_sum = 0; e8_car = 0; e_valid = 0; e_cnt = 0;
    endtask

    // One clock: drive at negedge, model the edge, check 1 time unit after it
    task automatic step(input string ctx, input logic v,
                        input logic a1, input logic b1, input logic c1,
                        input logic [7:0] a8, input logic [7:0] b8, input logic c8);
        int r;
        @(negedge clk);
        if1.in_valid = v; if1.a = a1; if1.b = b1; if1.cin = c1;
        if8.in_valid = v; if8.a = a8; if8.b = b8; if8.cin = c8;
        @(posedge clk);
        if (v) begin
            r = int'(a1) + int'(b1) + int'(c1);
            e1_sum = r % 2;   e1_car = r / 2;
            r = int'(a8) + int'(b8) + int'(c8);
            e8_sum = r % 256; e8_car = r / 256;
            e_cnt  = (e_cnt < 15) ? e_cnt + 1 : 15;
        end
        e_valid = v ? 1 : 0;
        #1;
        check_all(ctx);
    endtask

    task automatic rand_step(input string ctx, input logic v);
        step(ctx, v, 1'($urandom), 1'($urandom), 1'($urandom),
             8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    logic [2:0] combo;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        model_reset();
        rst = 1'b0;
        if1.in_valid = 1'b0; if1.a = 1'b0; if1.b = 1'b0; if1.cin = 1'b0;
        if8.in_valid = 1'b0; if8.a = 8'd0; if8.b = 8'd0; if8.cin = 1'b0;

        // reset state, with clocks running and valid offered
        #2;
        check_all("reset0");
        repeat (2) begin
            @(negedge clk);
            if1.in_valid = 1'b1; if1.a = 1'b1; if8.in_valid = 1'b1; if8.a = 8'd77;
            @(posedge clk); #1;
            check_all("reset_hold");
        end
        @(negedge clk);
        if1.in_valid = 1'b0; if8.in_valid = 1'b0;
        rst = 1'b1;

        // all 8 single-bit combinations
        for (int i = 0; i < 8; i++) begin
            combo = 3'(i);
            step("w1_combo", 1'b1, combo[2], combo[1], combo[0],
                 8'($urandom), 8'($urandom), 1'($urandom));
        end

        // directed 8-bit boundary vectors
        step("w8_ovf",  1'b1, 1'b1, 1'b1, 1'b1, 8'd255, 8'd0,   1'b1);
        check_eq("w8_255_0_1_sum", 64'(if8.sum), 64'd0);
        check_eq("w8_255_0_1_carry", 64'(if8.carry), 64'd1);
        check_eq("w1_111_sum", 64'(if1.sum), 64'd1);
        check_eq("w1_111_carry", 64'(if1.carry), 64'd1);
        step("w8_200", 1'b1, 1'b1, 1'b0, 1'b0, 8'd200, 8'd100, 1'b0);
        check_eq("w8_200_100_sum", 64'(if8.sum), 64'd44);
        check_eq("w8_200_100_carry", 64'(if8.carry), 64'd1);
        check_eq("w1_100_sum", 64'(if1.sum), 64'd1);
        check_eq("w1_100_carry", 64'(if1.carry), 64'd0);
        step("w8_3_4", 1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 8'd4, 1'b1);
        check_eq("w8_3_4_1_sum", 64'(if8.sum), 64'd8);
        check_eq("w8_3_4_1_carry", 64'(if8.carry), 64'd0);
        check_eq("w1_000_sum", 64'(if1.sum), 64'd0);

        // hold with in_valid low and random operands
        step("hold_load", 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 8'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            rand_step("hold", 1'b0);
            check_eq("hold_w1_sum0", 64'(if1.sum), 64'd0);
            check_eq("hold_w1_carry1", 64'(if1.carry), 64'd1);
            check_eq("hold_w1_valid0", 64'(if1.out_valid), 64'd0);
        end

        // back-to-back random stream, sometimes with gaps
        for (int i = 0; i < 100; i++) begin
            rand_step("stream", 1'b1);
        end
        for (int i = 0; i < 40; i++) begin
            rand_step("mixed", 1'(($urandom % 4) != 0));
        end

        // asynchronous reset mid-cycle while valid data is streaming
        rand_step("pre_rst", 1'b1);
        @(negedge clk);
        if1.in_valid = 1'b1; if8.in_valid = 1'b1; if8.a = 8'd250; if8.b = 8'd9;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk); #1;
        check_all("rst_no_replay");
        @(negedge clk);
        if1.in_valid = 1'b0; if8.in_valid = 1'b0;
        rst = 1'b1;

        // recovery, counter saturation, then hold
        for (int i = 0; i < 20; i++) begin
            rand_step("post_rst", 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            rand_step("post_idle", 1'b0);
        end
`ifdef FULL_ADDER_STATS_EN
        check_eq("cnt_sat15", 64'(if8.op_count), 64'd15);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
